// File: rtl/ss_seq_pkg.sv
// Save-state sequencer shared definitions.
// State encodings and bus widths for the mapper save-state port.
package ss_seq_pkg;

    localparam int BW_SS_ADDR = 8;
    localparam int BW_SS_DAT  = 8;

    typedef enum logic [2:0] {
        SS_ST_IDLE     = 3'd0,
        SS_ST_S_SET    = 3'd1,
        SS_ST_S_PUSH   = 3'd2,
        SS_ST_L_PULL   = 3'd3,
        SS_ST_L_STB_HI = 3'd4,
        SS_ST_L_STB_LO = 3'd5,
        SS_ST_FIN      = 3'd6
    } ss_state_t;

    // Last walked address for a given pass length (1..256).
    function automatic logic [BW_SS_ADDR-1:0] ss_last(input int len);
        return BW_SS_ADDR'(len - 1);
    endfunction

endpackage

// File: rtl/ss_seq.sv
// Save-state sequencer: walks mapper state addresses,
// streaming bytes out on save and writing bytes in on load.
module ss_seq
    import ss_seq_pkg::*;
#(
    parameter int SS_LEN  = 256,
    parameter int RD_WAIT = 2,
    parameter int WE_HOLD = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  save_req,
    input  logic                  load_req,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  ss_act,
    output logic                  ss_we,
    output logic                  ss_m2,
    output logic [BW_SS_ADDR-1:0] ss_addr,
    output logic [BW_SS_DAT-1:0]  ss_wdat,
    input  logic [BW_SS_DAT-1:0]  ss_rdat,
    output logic [BW_SS_DAT-1:0]  tx_dat,
    output logic                  tx_vld,
    input  logic                  tx_rdy,
    input  logic [BW_SS_DAT-1:0]  rx_dat,
    input  logic                  rx_vld,
    output logic                  rx_rdy
);

    localparam logic [BW_SS_ADDR-1:0] LAST = ss_last(SS_LEN);
    localparam logic [7:0] RD_END = 8'(RD_WAIT);
    // A zero hold still gives one high cycle so the mapper sees an edge.
    localparam logic [7:0] WE_END = 8'((WE_HOLD > 0) ? WE_HOLD - 1 : 0);

    ss_state_t             state, state_nx;
    logic [BW_SS_ADDR-1:0] addr, addr_nx;
    logic [7:0]            wcnt, wcnt_nx;
    logic [BW_SS_DAT-1:0]  txd, txd_nx;
    logic [BW_SS_DAT-1:0]  wdat, wdat_nx;
    logic                  err_q, err_nx;
    logic                  abort_hit;

    // Sequencer registers: state, address, shared wait counter, data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SS_ST_IDLE;
            addr  <= '0;
            wcnt  <= '0;
            txd   <= '0;
            wdat  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            addr  <= addr_nx;
            wcnt  <= wcnt_nx;
            txd   <= txd_nx;
            wdat  <= wdat_nx;
            err_q <= err_nx;
        end
    end

    // Next-state and port decode; outputs follow the current state.
    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        wcnt_nx  = wcnt;
        txd_nx   = txd;
        wdat_nx  = wdat;
        err_nx   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        ss_act   = 1'b0;
        ss_we    = 1'b0;
        ss_m2    = 1'b0;
        tx_vld   = 1'b0;
        rx_rdy   = 1'b0;
        // A completed pass in FIN is not turned into an error.
        abort_hit = abort
                 && (state != SS_ST_IDLE)
                 && (state != SS_ST_FIN);

        unique case (state)
            SS_ST_IDLE: begin
                if (save_req) begin
                    state_nx = SS_ST_S_SET;
                    addr_nx  = '0;
                    wcnt_nx  = '0;
                end else if (load_req) begin
                    state_nx = SS_ST_L_PULL;
                    addr_nx  = '0;
                    wcnt_nx  = '0;
                end
            end
            SS_ST_S_SET: begin
                busy   = 1'b1;
                ss_act = 1'b1;
                if (wcnt == RD_END) begin
                    txd_nx   = ss_rdat;
                    state_nx = SS_ST_S_PUSH;
                end else begin
                    wcnt_nx = wcnt + 8'd1;
                end
            end
            SS_ST_S_PUSH: begin
                busy   = 1'b1;
                ss_act = 1'b1;
                tx_vld = 1'b1;
                if (tx_rdy) begin
                    wcnt_nx = '0;
                    if (addr == LAST) begin
                        state_nx = SS_ST_FIN;
                    end else begin
                        addr_nx  = addr + 1'b1;
                        state_nx = SS_ST_S_SET;
                    end
                end
            end
            SS_ST_L_PULL: begin
                busy   = 1'b1;
                ss_act = 1'b1;
                rx_rdy = 1'b1;
                if (rx_vld) begin
                    wdat_nx  = rx_dat;
                    wcnt_nx  = '0;
                    state_nx = SS_ST_L_STB_HI;
                end
            end
            SS_ST_L_STB_HI: begin
                busy   = 1'b1;
                ss_act = 1'b1;
                ss_we  = 1'b1;
                ss_m2  = 1'b1;
                if (wcnt == WE_END) begin
                    state_nx = SS_ST_L_STB_LO;
                end else begin
                    wcnt_nx = wcnt + 8'd1;
                end
            end
            SS_ST_L_STB_LO: begin
                // m2 has fallen: the mapper write is done; hold we one cycle.
                busy   = 1'b1;
                ss_act = 1'b1;
                ss_we  = 1'b1;
                if (addr == LAST) begin
                    state_nx = SS_ST_FIN;
                end else begin
                    addr_nx  = addr + 1'b1;
                    state_nx = SS_ST_L_PULL;
                end
            end
            SS_ST_FIN: begin
                done     = 1'b1;
                ss_act   = 1'b1;
                state_nx = SS_ST_IDLE;
            end
            default: begin
                state_nx = SS_ST_IDLE;
            end
        endcase

        if (abort_hit) begin
            state_nx = SS_ST_IDLE;
            err_nx   = 1'b1;
        end
    end

    assign err     = err_q;
    assign ss_addr = addr;
    assign ss_wdat = wdat;
    assign tx_dat  = txd;

endmodule
